// File: rtl/odo_display_sched_pkg.sv
// Shared encodings and constants for the odometer display scheduler.
package odo_display_sched_pkg;

  // Display source arbitration states
  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_ODO = 2'd1,
    S_MSG = 2'd2
  } src_state_t;

  // Binary-to-BCD conversion engine states
  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_SHIFT = 2'd1,
    C_LOAD  = 2'd2
  } conv_state_t;

  // Message word: 8 glyph nibbles, leftmost digit in the top nibble
  localparam int unsigned MSG_W = 32;

  // Eight BCD digits cover both display groups
  localparam int unsigned BCD_W = 32;

  // Glyph nibbles with a non-numeric meaning
  localparam logic [3:0] GLYPH_DASH  = 4'hA;
  localparam logic [3:0] GLYPH_BLANK = 4'hF;

  // Largest value eight decimal digits can show
  localparam logic [63:0] SAT_LIMIT = 64'd99_999_999;

endpackage

// File: rtl/odo_display_sched_if.sv
// Message request channel between the gear FSM and the display scheduler.
interface odo_display_sched_if;
  import odo_display_sched_pkg::*;

  logic             msg_vld;
  logic [MSG_W-1:0] msg_code;
  logic             msg_rdy;

  // Requester side drives the message, scheduler answers with ready
  modport master (output msg_vld, output msg_code, input msg_rdy);
  modport slave  (input msg_vld, input msg_code, output msg_rdy);

endinterface

// File: rtl/odo_display_sched_seg7_glyph.sv
// Nibble-to-segment decoder, bit order {a,b,c,d,e,f,g,dp}, active-high.
module seg7_glyph
  import odo_display_sched_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] pat
);

  // Digits 0-9, a dash for A, everything else blank
  always_comb begin
    pat = 8'h00;
    case (nib)
      4'h0:       pat = 8'hFC;
      4'h1:       pat = 8'h60;
      4'h2:       pat = 8'hDA;
      4'h3:       pat = 8'hF2;
      4'h4:       pat = 8'h66;
      4'h5:       pat = 8'hB6;
      4'h6:       pat = 8'hBE;
      4'h7:       pat = 8'hE0;
      4'h8:       pat = 8'hFE;
      4'h9:       pat = 8'hF6;
      GLYPH_DASH: pat = 8'h02;
      default:    pat = 8'h00;
    endcase
  end

endmodule

// File: rtl/odo_display_sched.sv
// Display scheduler for two 4-digit seven-segment groups: multiplexed scan,
// fixed-priority source selection (off / message / odometer) and a
// sequential double-dabble converter feeding the odometer digits.
module odo_display_sched
  import odo_display_sched_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter int unsigned MSG_FRAMES = 250,
  parameter int unsigned REC_W      = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             power_on,
  input  logic [REC_W-1:0] record,
  odo_display_sched_if.slave msg,
  output logic             conv_busy,
  output logic [7:0]       an,
  output logic [7:0]       seg_l,
  output logic [7:0]       seg_r
);

  localparam int unsigned HOLD   = MSG_FRAMES * 4 * SCAN_DIV;
  localparam int unsigned HOLD_W = $clog2(HOLD + 1);
  localparam int unsigned DIV_W  = $clog2(SCAN_DIV + 1);
  localparam int unsigned IT_W   = $clog2(REC_W + 1);

  // Clamp values that cannot be shown on eight decimal digits
  function automatic logic [REC_W-1:0] sat_rec(input logic [REC_W-1:0] x);
    if (64'(x) > SAT_LIMIT) return SAT_LIMIT[REC_W-1:0];
    return x;
  endfunction

  // Double-dabble correction: bump every nibble >= 5 before the shift
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 8; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Replace zeros above the most significant nonzero digit by blanks;
  // digit 0 is never blanked so a zero reading still shows "0"
  function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = b;
    lead = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (lead && (b[4*i +: 4] == 4'd0)) r[4*i +: 4] = GLYPH_BLANK;
      else lead = 1'b0;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Scan timebase
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             scan_en;
  logic [1:0]       p;

  assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

  // Divider and digit pointer; the first tick only enables the scan so
  // that pointer 0 is the first slot shown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      scan_en <= 1'b0;
      p       <= 2'd0;
    end else if (tick) begin
      div_cnt <= '0;
      scan_en <= 1'b1;
      if (scan_en) p <= p + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Source FSM
  // ---------------------------------------------------------------------
  src_state_t        src_q, src_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [MSG_W-1:0]  msg_latch;
  logic              accept;

  assign accept = msg.msg_vld && (src_q == S_ODO);

  // Source state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) src_q <= S_OFF;
    else        src_q <= src_d;
  end

  // Source next state; losing power overrides everything
  always_comb begin
    src_d = src_q;
    case (src_q)
      S_OFF:   src_d = S_ODO;
      S_ODO:   if (accept) src_d = S_MSG;
      S_MSG:   if (hold_cnt == HOLD_W'(HOLD - 1)) src_d = S_ODO;
      default: src_d = S_OFF;
    endcase
    if (!power_on) src_d = S_OFF;
  end

  // Source outputs: messages are only taken while the odometer is shown
  always_comb begin
    msg.msg_rdy = (src_q == S_ODO);
  end

  // Message hold counter, cleared whenever the message ends or is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if ((src_q == S_MSG) && (src_d == S_MSG)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  // Message glyphs captured on the accepting edge
  always_ff @(posedge clk) begin
    if (accept) msg_latch <= msg.msg_code;
  end

  // ---------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------
  conv_state_t             conv_q, conv_d;
  logic [IT_W-1:0]         it_cnt;
  logic [REC_W-1:0]        last_rec;
  logic [REC_W-1:0]        bin_work;
  logic [BCD_W-1:0]        bcd_work;
  logic [BCD_W-1:0]        bcd_disp;
  logic [BCD_W+REC_W-1:0]  shift_p0;
  logic                    start_conv;

  assign start_conv = (conv_q == C_IDLE) && (conv_d == C_SHIFT);

  // One add-3-then-shift step over the combined BCD/binary register
  always_comb begin
    shift_p0 = {add3(bcd_work), bin_work} << 1;
  end

  // Conversion state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conv_q <= C_IDLE;
    else        conv_q <= conv_d;
  end

  // Conversion next state; record changes are only looked at in idle
  always_comb begin
    conv_d = conv_q;
    case (conv_q)
      C_IDLE:  if (record != last_rec) conv_d = C_SHIFT;
      C_SHIFT: if (it_cnt == IT_W'(REC_W - 1)) conv_d = C_LOAD;
      C_LOAD:  conv_d = C_IDLE;
      default: conv_d = C_IDLE;
    endcase
  end

  // Conversion outputs
  always_comb begin
    conv_busy = (conv_q != C_IDLE);
  end

  // Conversion control: last sampled value, iteration count, display copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rec <= '0;
      it_cnt   <= '0;
      bcd_disp <= '0;
    end else begin
      if (start_conv)         last_rec <= record;
      if (start_conv)         it_cnt   <= '0;
      else if (conv_q == C_SHIFT) it_cnt <= it_cnt + IT_W'(1);
      if (conv_q == C_LOAD)   bcd_disp <= bcd_work;
    end
  end

  // Conversion datapath: load the clamped sample, then shift REC_W times
  always_ff @(posedge clk) begin
    if (start_conv) begin
      bin_work <= sat_rec(record);
      bcd_work <= '0;
    end else if (conv_q == C_SHIFT) begin
      bcd_work <= shift_p0[BCD_W+REC_W-1:REC_W];
      bin_work <= shift_p0[REC_W-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Display path: p0 = glyph selection, p1 = pin registers
  // ---------------------------------------------------------------------
  logic [BCD_W-1:0] frame_p0;
  logic [3:0]       nib_l_p0, nib_r_p0;
  logic [7:0]       an_p0, pat_l_p0, pat_r_p0;
  logic [7:0]       an_p1, seg_l_p1, seg_r_p1;

  // Pick the eight glyph nibbles of the winning source
  always_comb begin
    frame_p0 = {8{GLYPH_BLANK}};
    case (src_q)
      S_ODO:   frame_p0 = blank_lz(bcd_disp);
      S_MSG:   frame_p0 = msg_latch;
      default: frame_p0 = {8{GLYPH_BLANK}};
    endcase
  end

  // Pointer p lights digit 7-p on the left group and 3-p on the right
  always_comb begin
    case (p)
      2'd0: begin
        an_p0 = 8'h88; nib_l_p0 = frame_p0[31:28]; nib_r_p0 = frame_p0[15:12];
      end
      2'd1: begin
        an_p0 = 8'h44; nib_l_p0 = frame_p0[27:24]; nib_r_p0 = frame_p0[11:8];
      end
      2'd2: begin
        an_p0 = 8'h22; nib_l_p0 = frame_p0[23:20]; nib_r_p0 = frame_p0[7:4];
      end
      default: begin
        an_p0 = 8'h11; nib_l_p0 = frame_p0[19:16]; nib_r_p0 = frame_p0[3:0];
      end
    endcase
  end

  seg7_glyph u_glyph_l (
    .nib (nib_l_p0),
    .pat (pat_l_p0)
  );

  seg7_glyph u_glyph_r (
    .nib (nib_r_p0),
    .pat (pat_r_p0)
  );

  // Pin registers stay dark until the scan has started
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1    <= 8'h00;
      seg_l_p1 <= 8'h00;
      seg_r_p1 <= 8'h00;
    end else if (scan_en) begin
      an_p1    <= an_p0;
      seg_l_p1 <= pat_l_p0;
      seg_r_p1 <= pat_r_p0;
    end
  end

  assign an    = an_p1;
  assign seg_l = seg_l_p1;
  assign seg_r = seg_r_p1;

endmodule

// File: tb/tb_odo_display_sched.sv
// Scoreboard bench for odo_display_sched: expected display frames and
// conversion busy lengths are queued by the stimulus and consumed by
// independent monitors.
module tb_odo_display_sched;

  localparam int unsigned SCAN_DIV   = 4;
  localparam int unsigned MSG_FRAMES = 2;
  localparam int unsigned REC_W      = 27;
  localparam int          HOLD       = MSG_FRAMES * 4 * SCAN_DIV;
  localparam int          BUSY_LEN   = REC_W + 1;

  // Expected frames, digit i pattern in bits [8*i+7:8*i]
  localparam logic [63:0] F_BLANK = 64'h00000000_00000000;
  localparam logic [63:0] F_1208  = 64'h00000000_60DAFCFE;
  localparam logic [63:0] F_SAT   = 64'hF6F6F6F6_F6F6F6F6;
  localparam logic [63:0] F_ZERO  = 64'h00000000_000000FC;
  localparam logic [63:0] F_DASH  = 64'h02020202_02020202;
  localparam logic [63:0] F_MIX   = 64'hFC026000_DA00F200;
  localparam logic [63:0] F_4321  = 64'h00000000_66F2DA60;
  localparam logic [63:0] F_56    = 64'h00000000_0000B6BE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             power_on = 1'b0;
  logic [REC_W-1:0] record = '0;
  logic             conv_busy;
  logic [7:0]       an, seg_l, seg_r;

  odo_display_sched_if mif();

  odo_display_sched #(
    .SCAN_DIV   (SCAN_DIV),
    .MSG_FRAMES (MSG_FRAMES),
    .REC_W      (REC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .power_on  (power_on),
    .record    (record),
    .msg       (mif),
    .conv_busy (conv_busy),
    .an        (an),
    .seg_l     (seg_l),
    .seg_r     (seg_r)
  );

  always #5 clk = ~clk;

  int          errs = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];
  int          busy_q[$];
  int          slot_n = 0;
  logic [7:0]  prev_an = 8'h00;
  int          bcnt = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  function automatic int slot_of(input logic [7:0] a);
    case (a)
      8'h88:   return 0;
      8'h44:   return 1;
      8'h22:   return 2;
      8'h11:   return 3;
      default: return -1;
    endcase
  endfunction

  // Compare the currently lit slot against a full expected frame
  task automatic check_slot(input string nm, input logic [63:0] f);
    int s;
    s = slot_of(an);
    if (s < 0) begin
      checks++;
      errs++;
      $display("FAIL %s: anode pattern %0h is not a valid slot", nm, an);
    end else begin
      chk(nm, {seg_l, seg_r}, {f[8*(7-s) +: 8], f[8*(3-s) +: 8]});
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input string nm, input logic [63:0] f);
    exp_q.push_back(f);
    name_q.push_back(nm);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errs++;
      $display("FAIL %s: frame not fully observed within %0d cycles", nm, n);
      exp_q.delete();
      name_q.delete();
      slot_n = 0;
    end
  endtask

  task automatic wait_conv(input string nm);
    bit seen, done;
    seen = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (conv_busy) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errs++;
      $display("FAIL %s: conversion did not complete, busy_seen=%0d required 1", nm, seen);
    end
  endtask

  // Display monitor: scan order on every slot change, frame contents when queued
  initial begin
    forever begin
      @(negedge clk);
      if (an != prev_an) begin
        if (prev_an != 8'h00 && an != 8'h00)
          chk("scan_order", an, {prev_an[0], prev_an[7:1]});
        if (an != 8'h00 && exp_q.size() > 0) begin
          check_slot(name_q[0], exp_q[0]);
          slot_n++;
          if (slot_n == 4) begin
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
            slot_n = 0;
          end
        end
        prev_an = an;
      end
    end
  end

  // Busy monitor: each completed busy pulse is matched against the queue
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0;
      end else if (conv_busy) begin
        bcnt++;
      end else if (bcnt > 0) begin
        if (busy_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL busy_len: unexpected pulse of %0d cycles, none required", bcnt);
        end else begin
          chk("busy_len", bcnt, busy_q.pop_front());
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mif.msg_vld  = 1'b0;
    mif.msg_code = '0;

    // Reset values
    step(3);
    chk("reset_an", an, 0);
    chk("reset_seg", {seg_l, seg_r}, 0);
    chk("reset_rdy", mif.msg_rdy, 0);
    chk("reset_busy", conv_busy, 0);
    rst_n = 1'b1;
    step(1);
    chk("pre_tick_an", an, 0);

    // Power off: blank scan
    push_frame("off_blank", F_BLANK);
    wait_drain("off_blank");

    // Power on with a mid-range reading
    step(1);
    power_on = 1'b1;
    record   = 27'd1208;
    busy_q.push_back(BUSY_LEN);
    step(1);
    chk("rdy_on", mif.msg_rdy, 1);
    wait_conv("conv_1208");
    push_frame("odo_1208", F_1208);
    wait_drain("odo_1208");

    // Saturation
    step(1);
    record = 27'd134_217_727;
    busy_q.push_back(BUSY_LEN);
    wait_conv("conv_sat");
    push_frame("odo_sat", F_SAT);
    wait_drain("odo_sat");

    // Zero shows a single digit
    step(1);
    record = 27'd0;
    busy_q.push_back(BUSY_LEN);
    wait_conv("conv_zero");
    push_frame("odo_zero", F_ZERO);
    wait_drain("odo_zero");

    step(1);
    record = 27'd1208;
    busy_q.push_back(BUSY_LEN);
    wait_conv("conv_1208b");
    push_frame("odo_1208b", F_1208);
    wait_drain("odo_1208b");

    // Dash message and its hold time
    step(1);
    chk("rdy_before_msg", mif.msg_rdy, 1);
    mif.msg_code = 32'hAAAA_AAAA;
    mif.msg_vld  = 1'b1;
    step(1);
    mif.msg_vld = 1'b0;
    chk("rdy_drop", mif.msg_rdy, 0);
    push_frame("msg_dash", F_DASH);
    n = 0;
    while (!mif.msg_rdy && n < 200) begin
      n++;
      step(1);
    end
    chk("msg_hold_cycles", n, HOLD);
    wait_drain("msg_dash");
    push_frame("odo_after_msg", F_1208);
    wait_drain("odo_after_msg");

    // Mixed-glyph message cut by power loss
    step(1);
    mif.msg_code = 32'h0A1B_2C3D;
    mif.msg_vld  = 1'b1;
    step(1);
    mif.msg_vld = 1'b0;
    push_frame("msg_mixed", F_MIX);
    wait_drain("msg_mixed");
    step(1);
    power_on = 1'b0;
    step(2);
    chk("off_seg_next", {seg_l, seg_r}, 0);
    push_frame("off_during_msg", F_BLANK);
    wait_drain("off_during_msg");
    step(1);
    power_on = 1'b1;
    step(1);
    chk("rdy_restore", mif.msg_rdy, 1);
    push_frame("odo_restored", F_1208);
    wait_drain("odo_restored");
    step(40);
    push_frame("odo_stays", F_1208);
    wait_drain("odo_stays");

    // Record change during a conversion
    step(1);
    record = 27'd4321;
    busy_q.push_back(BUSY_LEN);
    busy_q.push_back(BUSY_LEN);
    step(6);
    record = 27'd56;
    wait_conv("conv_first");
    step(1);
    check_slot("first_result_old", F_4321);
    wait_conv("conv_second");
    push_frame("odo_56", F_56);
    wait_drain("odo_56");

    // Reset in the middle of a conversion
    step(1);
    record = 27'd1208;
    step(10);
    rst_n = 1'b0;
    #1;
    chk("midreset_an", an, 0);
    chk("midreset_seg", {seg_l, seg_r}, 0);
    chk("midreset_busy", conv_busy, 0);
    chk("midreset_rdy", mif.msg_rdy, 0);
    step(2);
    rst_n = 1'b1;
    busy_q.push_back(BUSY_LEN);
    wait_conv("conv_after_reset");
    push_frame("odo_after_reset", F_1208);
    wait_drain("odo_after_reset");

    step(5);
    chk("busy_queue_empty", busy_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
